// File: rtl/pulse_stretcher_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretcher_pkg
// Shared definitions for the pulse stretcher: FSM state encoding and the
// tick-counter width helper.
// -----------------------------------------------------------------------------
package pulse_stretcher_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_ON   = 2'd1;
  localparam logic [1:0] STATE_OFF  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = STATE_IDLE,
    S_ON   = STATE_ON,
    S_OFF  = STATE_OFF
  } state_t;

  // Width of the shared tick counter: wide enough for the longer phase plus
  // one spare bit.
  function automatic int tick_cnt_width(input int on_ticks, input int off_ticks);
    int longest;
    longest = (on_ticks > off_ticks) ? on_ticks : off_ticks;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/pulse_stretcher_tick_counter.sv
// -----------------------------------------------------------------------------
// tick_counter
// Width-parameterised up-counter used to time both the ON and OFF phases.
// Ports:
//   clk, rst     clock / asynchronous active-high reset
//   clear        synchronous clear to zero (wins over enable)
//   enable       increment by one on this edge
//   terminal     compare value for the current phase
//   count        current count
//   at_terminal  count == terminal (combinational compare)
// -----------------------------------------------------------------------------
module tick_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign at_terminal = (count == terminal);

endmodule

// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
// Turns single-cycle requests into pulses with a minimum high time of ON_TICKS
// and a minimum low gap of OFF_TICKS, both counted in clock_enable ticks.
// Optional feature (macro PULSE_STRETCHER_QUEUE_EN): requests arriving while
// busy are queued up to QUEUE_DEPTH instead of being dropped.
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   clock_enable  one-cycle tick strobe
//   in_pulse      request; every high cycle is one request
//   out_signal    stretched pulse (registered)
//   busy          high whenever not idle (registered)
//   dropped       one-cycle strobe: a request was discarded (registered)
// -----------------------------------------------------------------------------
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int ON_TICKS    = 512,
  parameter int OFF_TICKS   = 512,
  parameter int QUEUE_DEPTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clock_enable,
  input  logic in_pulse,
  output logic out_signal,
  output logic busy,
  output logic dropped
);

  localparam int              CW       = tick_cnt_width(ON_TICKS, OFF_TICKS);
  localparam logic [CW-1:0]   ON_LAST  = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0]   OFF_LAST = CW'(OFF_TICKS - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_term;
  logic            at_term, phase_done;
  logic            req_busy, has_pending, drop_nx;

  // One counter serves both phases; only the terminal value changes.
  assign cnt_term   = (state == S_OFF) ? OFF_LAST : ON_LAST;
  assign phase_done = clock_enable && at_term && (state != S_IDLE);
  assign req_busy   = in_pulse && (state != S_IDLE);

  tick_counter #(.WIDTH(CW)) u_tick_counter (
    .clk         (clk),
    .rst         (rst),
    .clear       ((state == S_IDLE) || phase_done),
    .enable      (clock_enable && (state != S_IDLE)),
    .terminal    (cnt_term),
    .count       (cnt),
    .at_terminal (at_term)
  );

`ifdef PULSE_STRETCHER_QUEUE_EN
  localparam int            PW     = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PW-1:0] Q_FULL = PW'(QUEUE_DEPTH);

  logic [PW-1:0] pending, pending_nx;
  logic          deq;

  assign has_pending = (pending != '0);
  // A queued request is consumed when idle without a fresh request, or when
  // the OFF gap ends.
  assign deq = has_pending &&
               (((state == S_IDLE) && !in_pulse) || ((state == S_OFF) && phase_done));

  always_comb begin
    pending_nx = pending;
    drop_nx    = 1'b0;
    if (req_busy && deq) begin
      pending_nx = pending;            // enqueue and dequeue cancel out
    end else if (req_busy) begin
      if (pending < Q_FULL) pending_nx = pending + 1'b1;
      else                  drop_nx    = 1'b1;
    end else if (deq) begin
      pending_nx = pending - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nx;
  end
`else
  assign has_pending = 1'b0;
  assign drop_nx     = req_busy;
`endif

  // NOTE: every combinational output gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (in_pulse || has_pending) state_nx = S_ON;
      S_ON:   if (phase_done)              state_nx = S_OFF;
      S_OFF:  if (phase_done)              state_nx = has_pending ? S_ON : S_IDLE;
      default:                             state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state value so they change on the
  // same edge as the state and never see a combinational input path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      out_signal <= 1'b0;
      busy       <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      state      <= state_nx;
      out_signal <= (state_nx == S_ON);
      busy       <= (state_nx != S_IDLE);
      dropped    <= drop_nx;
    end
  end

endmodule
